// File: rtl/exsram_wbuf.sv
// exsram_wbuf -- posted-write buffer and read sequencer between the CPU data
// bus and the external SRAM controller.
//
// Writes are acknowledged as soon as they enter a DEPTH-entry FIFO, which
// drains to the SRAM controller in order. A read whose address exactly
// matches an occupied FIFO entry is answered from the youngest match. Any
// other read waits for the FIFO to drain, then goes downstream.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   stb, i_rw          upstream request strobe (pulse), 1 = write / 0 = read
//   i_addr, i_dtw      upstream byte address / write data
//   ack, dtr           upstream completion pulse / read data (held)
//   m_stb, m_rw        downstream strobe (pulse) / write flag
//   m_addr, m_dtw      downstream address / write data (held until m_ack)
//   m_ack, m_dtr       downstream completion pulse / read data
//   empty, count       FIFO empty and downstream idle / FIFO occupancy
module exsram_wbuf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stb,
    input  logic          i_rw,
    input  logic [31:0]   i_addr,
    input  logic [31:0]   i_dtw,
    output logic          ack,
    output logic [31:0]   dtr,
    output logic          m_stb,
    output logic          m_rw,
    output logic [31:0]   m_addr,
    output logic [31:0]   m_dtw,
    input  logic          m_ack,
    input  logic [31:0]   m_dtr,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {U_IDLE, U_WFULL, U_RWAIT} ustate_t;
    typedef enum logic       {D_IDLE, D_WAIT}           dstate_t;

    ustate_t u_state_q, u_state_d;
    dstate_t d_state_q, d_state_d;

    logic [31:0]   mem_addr_q [DEPTH];
    logic [31:0]   mem_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   req_addr_q, req_data_q;
    logic          d_rd_q;

    logic          ack_q, ack_d;
    logic [31:0]   dtr_q, dtr_d;
    logic          m_stb_q, m_stb_d;
    logic          m_rw_q, m_rw_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_dtw_q, m_dtw_d;
    logic          empty_q, empty_d;

    logic          not_full, up_stb, push, pop, d_done, rd_done;
    logic          issue_wr, issue_rd;
    logic [31:0]   push_addr, push_data;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic [AW-1:0] fwd_idx;

    assign not_full  = (count_q < DEPTH_C);
    assign up_stb    = (u_state_q == U_IDLE) && stb;
    assign push      = (up_stb && i_rw && not_full) || ((u_state_q == U_WFULL) && not_full);
    assign push_addr = (u_state_q == U_WFULL) ? req_addr_q : i_addr;
    assign push_data = (u_state_q == U_WFULL) ? req_data_q : i_dtw;
    assign d_done    = (d_state_q == D_WAIT) && m_ack;
    assign pop       = d_done && !d_rd_q;
    assign rd_done   = d_done && d_rd_q;
    // Buffered writes always win; the read only goes out once the FIFO is dry.
    assign issue_wr  = (d_state_q == D_IDLE) && (count_q != '0);
    assign issue_rd  = (d_state_q == D_IDLE) && (count_q == '0) && (u_state_q == U_RWAIT);

    // Forwarding: walk occupied entries oldest to youngest so the youngest
    // match wins; slots outside [rd_ptr, rd_ptr+count) never match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + AW'(i);
            if (((AW+1)'(i) < count_q) && (mem_addr_q[fwd_idx] == i_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[fwd_idx];
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            u_state_q  <= U_IDLE;
            d_state_q  <= D_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            d_rd_q     <= 1'b0;
            ack_q      <= 1'b0;
            dtr_q      <= '0;
            m_stb_q    <= 1'b0;
            m_rw_q     <= 1'b0;
            m_addr_q   <= '0;
            m_dtw_q    <= '0;
            empty_q    <= 1'b1;
        end else begin
            u_state_q <= u_state_d;
            d_state_q <= d_state_d;
            count_q   <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (up_stb) begin
                req_addr_q <= i_addr;
                req_data_q <= i_dtw;
            end
            if (issue_wr || issue_rd) d_rd_q <= !issue_wr;
            ack_q    <= ack_d;
            dtr_q    <= dtr_d;
            m_stb_q  <= m_stb_d;
            m_rw_q   <= m_rw_d;
            m_addr_q <= m_addr_d;
            m_dtw_q  <= m_dtw_d;
            empty_q  <= empty_d;
        end
    end

    // FIFO storage; stale contents are harmless since only occupied slots are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= push_addr;
            mem_data_q[wr_ptr_q] <= push_data;
        end
    end

    // Next-state logic
    always_comb begin
        u_state_d = u_state_q;
        unique case (u_state_q)
            U_IDLE: begin
                if (stb) begin
                    if (i_rw) begin
                        if (!not_full) u_state_d = U_WFULL;
                    end else if (!fwd_hit) begin
                        u_state_d = U_RWAIT;
                    end
                end
            end
            U_WFULL: if (not_full) u_state_d = U_IDLE;
            U_RWAIT: if (rd_done)  u_state_d = U_IDLE;
            default: u_state_d = U_IDLE;
        endcase

        d_state_d = d_state_q;
        unique case (d_state_q)
            D_IDLE:  if (issue_wr || issue_rd) d_state_d = D_WAIT;
            D_WAIT:  if (m_ack)                d_state_d = D_IDLE;
            default: d_state_d = D_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ack_d = push || (up_stb && !i_rw && fwd_hit) || rd_done;

        dtr_d = dtr_q;
        if (up_stb && !i_rw && fwd_hit) dtr_d = fwd_data;
        if (rd_done)                    dtr_d = m_dtr;

        m_stb_d  = issue_wr || issue_rd;
        m_rw_d   = m_rw_q;
        m_addr_d = m_addr_q;
        m_dtw_d  = m_dtw_q;
        if (issue_wr) begin
            m_rw_d   = 1'b1;
            m_addr_d = mem_addr_q[rd_ptr_q];
            m_dtw_d  = mem_data_q[rd_ptr_q];
        end else if (issue_rd) begin
            m_rw_d   = 1'b0;
            m_addr_d = req_addr_q;
        end

        empty_d = (count_d == '0) && (d_state_d == D_IDLE) && (u_state_d != U_RWAIT);
    end

    assign ack    = ack_q;
    assign dtr    = dtr_q;
    assign m_stb  = m_stb_q;
    assign m_rw   = m_rw_q;
    assign m_addr = m_addr_q;
    assign m_dtw  = m_dtw_q;
    assign empty  = empty_q;
    assign count  = count_q;

endmodule

// File: tb/tb_exsram_wbuf.sv
// Directed bench for exsram_wbuf: posted writes, full stall, forwarding,
// drain-before-read, pointer wrap, simultaneous push/pop and mid-transfer reset.
module tb_exsram_wbuf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stb = 1'b0;
    logic        i_rw = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_dtw = '0;
    logic        ack;
    logic [31:0] dtr;
    logic        m_stb;
    logic        m_rw;
    logic [31:0] m_addr;
    logic [31:0] m_dtw;
    logic        m_ack = 1'b0;
    logic [31:0] m_dtr = '0;
    logic        empty;
    logic [2:0]  count;

    exsram_wbuf #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .stb(stb), .i_rw(i_rw), .i_addr(i_addr),
        .i_dtw(i_dtw), .ack(ack), .dtr(dtr), .m_stb(m_stb), .m_rw(m_rw),
        .m_addr(m_addr), .m_dtw(m_dtw), .m_ack(m_ack), .m_dtr(m_dtr),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t  evq[$];
    ev_t  ev_tmp;
    int   n_acked = 0;
    int   max_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Record every downstream strobe and the peak occupancy.
    always @(negedge clk) begin
        if (m_stb) begin
            ev_tmp.rw = m_rw;
            ev_tmp.a  = m_addr;
            ev_tmp.d  = m_dtw;
            evq.push_back(ev_tmp);
        end
        if (int'(count) > max_cnt) max_cnt = int'(count);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d);
        stb = 1'b1; i_rw = rw; i_addr = a; i_dtw = d;
        step();
        stb = 1'b0;
    endtask

    task automatic pulse_mack(input logic [31:0] d);
        m_dtr = d; m_ack = 1'b1;
        step();
        m_ack = 1'b0;
    endtask

    task automatic wait_ev();
        int k = 0;
        while (evq.size() <= n_acked && k < 30) begin
            step();
            k++;
        end
        if (evq.size() <= n_acked) chk("ds_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            wait_ev();
            pulse_mack(32'h0);
            n_acked++;
        end
    endtask

    task automatic clr();
        evq.delete();
        n_acked = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_dtr",   dtr, 32'd0);
        chk("rst_mstb",  32'(m_stb), 32'd0);
        chk("rst_mrw",   32'(m_rw), 32'd0);
        chk("rst_maddr", m_addr, 32'd0);
        chk("rst_mdtw",  m_dtw, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Single posted write
        clr();
        req(1'b1, 32'h100, 32'hDEADBEEF);
        chk("w1_ack",   32'(ack), 32'd1);
        chk("w1_count", 32'(count), 32'd1);
        step();
        chk("w1_mstb",  32'(m_stb), 32'd1);
        chk("w1_maddr", m_addr, 32'h100);
        chk("w1_mdtw",  m_dtw, 32'hDEADBEEF);
        chk("w1_mrw",   32'(m_rw), 32'd1);
        chk("w1_ack2",  32'(ack), 32'd0);
        step();
        chk("w1_mstb_pulse", 32'(m_stb), 32'd0);
        chk("w1_hold",  m_addr, 32'h100);
        pulse_mack(32'h0);
        chk("w1_count0", 32'(count), 32'd0);
        chk("w1_empty",  32'(empty), 32'd1);

        // Five writes, downstream stalled: fifth waits for a slot
        clr();
        for (int k = 0; k < 4; k++) begin
            req(1'b1, 32'(k * 4), 32'hA0 + 32'(k));
            chk("fill_ack", 32'(ack), 32'd1);
        end
        chk("fill_count", 32'(count), 32'd4);
        req(1'b1, 32'h10, 32'hA4);
        chk("full_noack", 32'(ack), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        step();
        chk("full_noack2", 32'(ack), 32'd0);
        pulse_mack(32'h0);
        n_acked++;
        chk("pop_noack", 32'(ack), 32'd0);
        chk("pop_count", 32'(count), 32'd3);
        step();
        chk("late_ack",   32'(ack), 32'd1);
        chk("late_count", 32'(count), 32'd4);
        drain(4);
        chk("five_n", 32'(evq.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("five_addr", evq[k].a, 32'(k * 4));
            chk("five_data", evq[k].d, 32'hA0 + 32'(k));
        end
        step();
        chk("five_empty", 32'(empty), 32'd1);

        // Forwarding from youngest of two same-address entries
        clr();
        req(1'b1, 32'h20, 32'h11);
        req(1'b1, 32'h20, 32'h22);
        req(1'b0, 32'h20, 32'h0);
        chk("fwd_ack", 32'(ack), 32'd1);
        chk("fwd_dtr", dtr, 32'h22);
        step(); step(); step();
        chk("fwd_dtr_hold", dtr, 32'h22);
        chk("fwd_ack_pulse", 32'(ack), 32'd0);
        drain(2);
        chk("fwd_n", 32'(evq.size()), 32'd2);
        chk("fwd_rw0", 32'(evq[0].rw), 32'd1);
        chk("fwd_rw1", 32'(evq[1].rw), 32'd1);
        chk("fwd_d0", evq[0].d, 32'h11);
        chk("fwd_d1", evq[1].d, 32'h22);

        // Partial-overlap read drains the write first
        clr();
        req(1'b1, 32'h40, 32'h55);
        req(1'b0, 32'h42, 32'h0);
        chk("miss_noack", 32'(ack), 32'd0);
        chk("miss_notempty", 32'(empty), 32'd0);
        drain(1);
        wait_ev();
        chk("rd_mrw",   32'(m_rw), 32'd0);
        chk("rd_maddr", m_addr, 32'h42);
        chk("rd_noack", 32'(ack), 32'd0);
        pulse_mack(32'hCAFEF00D);
        n_acked++;
        chk("rd_ack", 32'(ack), 32'd1);
        chk("rd_dtr", dtr, 32'hCAFEF00D);
        step();
        chk("rd_ack_pulse", 32'(ack), 32'd0);
        chk("rd_dtr_hold", dtr, 32'hCAFEF00D);
        chk("rd_empty", 32'(empty), 32'd1);
        chk("rd_n", 32'(evq.size()), 32'd2);
        chk("rd_first_w", evq[0].a, 32'h40);
        chk("rd_first_rw", 32'(evq[0].rw), 32'd1);

        // 3 x DEPTH writes across pointer wrap
        clr();
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++) begin
                req(1'b1, 32'h200 + 32'((r * 4 + k) * 4), 32'h1000 + 32'(r * 4 + k));
                chk("wrap_ack", 32'(ack), 32'd1);
            end
            drain(4);
        end
        chk("wrap_n", 32'(evq.size()), 32'd12);
        for (int k = 0; k < 12; k++) begin
            chk("wrap_addr", evq[k].a, 32'h200 + 32'(k * 4));
            chk("wrap_data", evq[k].d, 32'h1000 + 32'(k));
        end
        chk("max_count", 32'(max_cnt), 32'd4);

        // Push and pop in the same cycle
        clr();
        step();
        req(1'b1, 32'h400, 32'h1);
        wait_ev();
        stb = 1'b1; i_rw = 1'b1; i_addr = 32'h404; i_dtw = 32'h2;
        m_ack = 1'b1;
        step();
        stb = 1'b0; m_ack = 1'b0;
        n_acked++;
        chk("pp_ack",   32'(ack), 32'd1);
        chk("pp_count", 32'(count), 32'd1);
        drain(1);
        chk("pp_addr1", evq[1].a, 32'h404);
        chk("pp_count0", 32'(count), 32'd0);

        // Reset with two writes buffered and a read pending
        clr();
        step();
        req(1'b1, 32'h300, 32'h3);
        req(1'b1, 32'h304, 32'h4);
        req(1'b0, 32'h308, 32'h0);
        chk("pre_rst_noack", 32'(ack), 32'd0);
        chk("pre_rst_count", 32'(count), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr_ack",   32'(ack), 32'd0);
        chk("mr_dtr",   dtr, 32'd0);
        chk("mr_mstb",  32'(m_stb), 32'd0);
        chk("mr_mrw",   32'(m_rw), 32'd0);
        chk("mr_maddr", m_addr, 32'd0);
        chk("mr_mdtw",  m_dtw, 32'd0);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_empty", 32'(empty), 32'd1);
        for (int k = 0; k < 4; k++) begin
            m_ack = (k % 2 == 0);
            m_dtr = 32'hBAD0BAD0;
            step();
            chk("stray_ack",   32'(ack), 32'd0);
            chk("stray_mstb",  32'(m_stb), 32'd0);
            chk("stray_count", 32'(count), 32'd0);
            chk("stray_empty", 32'(empty), 32'd1);
        end
        m_ack = 1'b0;
        step();
        chk("stray_dtr", dtr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
